// File: rtl/uio_bus_arbiter_if.sv
// Bundle of request, grant and pad signals shared between the UIO requesters
// and the bus arbiter.
interface uio_bus_arbiter_if #(
   parameter int NREQ = 4
) ();
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   dir;
   logic [8*NREQ-1:0] wdata;
   logic [NREQ-1:0]   gnt;
   logic [2:0]        owner_id;
   logic [7:0]        rdata;
   logic [7:0]        uio_in;
   logic [7:0]        uio_out;
   logic [7:0]        uio_oe;

   modport slave (
      input  req, dir, wdata, uio_in,
      output gnt, owner_id, rdata, uio_out, uio_oe
   );

   modport master (
      output req, dir, wdata, uio_in,
      input  gnt, owner_id, rdata, uio_out, uio_oe
   );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the 8-bit UIO pads with released-bus turnaround.
// Define UIO_ARB_TIMEOUT_EN to preempt an owner holding MAX_HOLD cycles under contention.
module uio_bus_arbiter #(
   parameter int NREQ        = 4,
   parameter int TURN_CYCLES = 1,
   parameter int MAX_HOLD    = 16
) (
   input logic            clk,
   input logic            rst,
   uio_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

   if (NREQ < 2 || NREQ > 8 || TURN_CYCLES < 1 || TURN_CYCLES > 7 ||
       MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
      $error("uio_bus_arbiter: parameter out of range");
   end

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [2:0]      owner_q, owner_d, last_q, last_d;
   logic [2:0]      turn_q, turn_d;
   logic [7:0]      out_q, out_d, oe_q, oe_d, rdata_q;
   logic            own_req, own_dir, other_req, found, preempt;
   logic [7:0]      own_wdata;
   logic [2:0]      winner;
`ifdef UIO_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);
   logic [7:0] hold_q, hold_d;
`endif

   // Round-robin pick: lowest index above last_q wins, else lowest index at or below.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (bus.req[i] && i <= int'(last_q)) begin found = 1'b1; winner = 3'(i); end
      for (int i = NREQ - 1; i >= 0; i--)
         if (bus.req[i] && i > int'(last_q)) begin found = 1'b1; winner = 3'(i); end
   end

   // gnt_q is one-hot on the owner while in OWN, so it doubles as the owner select.
   always_comb begin
      own_req   = |(bus.req & gnt_q);
      own_dir   = |(bus.dir & gnt_q);
      other_req = |(bus.req & ~gnt_q);
      own_wdata = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt_q[i]) own_wdata = bus.wdata[8*i +: 8];
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      last_d  = last_q;
      turn_d  = turn_q;
      oe_d    = '0;
      out_d   = out_q;
`ifdef UIO_ARB_TIMEOUT_EN
      hold_d  = hold_q;
      preempt = (hold_q == HOLD_MAX) && other_req;
`else
      preempt = 1'b0;
`endif
      case (state_q)
         IDLE: if (found) begin
            state_d = OWN;
            for (int i = 0; i < NREQ; i++) gnt_d[i] = (winner == 3'(i));
            owner_d = winner;
            last_d  = winner;
`ifdef UIO_ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
         end
         OWN: begin
            oe_d  = {8{own_dir}};
            out_d = own_wdata;
`ifdef UIO_ARB_TIMEOUT_EN
            if (hold_q != HOLD_MAX) hold_d = hold_q + 8'd1;
`endif
            if (!own_req || preempt) begin
               state_d = TURN;
               gnt_d   = '0;
               turn_d  = '0;
            end
         end
         TURN: begin
            if (turn_q == 3'(TURN_CYCLES - 1)) state_d = IDLE;
            else                               turn_d  = turn_q + 3'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         last_q  <= 3'(NREQ - 1);
         turn_q  <= '0;
         out_q   <= '0;
         oe_q    <= '0;
         rdata_q <= '0;
`ifdef UIO_ARB_TIMEOUT_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         turn_q  <= turn_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         rdata_q <= bus.uio_in;
`ifdef UIO_ARB_TIMEOUT_EN
         hold_q  <= hold_d;
`endif
      end
   end

   assign bus.gnt      = gnt_q;
   assign bus.owner_id = owner_q;
   assign bus.rdata    = rdata_q;
   assign bus.uio_out  = out_q;
   assign bus.uio_oe   = oe_q;
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: expected grants and readback values are
// queued as stimulus is driven and popped when the DUT presents them.
module tb_uio_bus_arbiter;
   localparam int NREQ = 4;
   localparam int TC   = 2;
   localparam int MH   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   typedef struct { logic [NREQ-1:0] gnt; logic [2:0] id; } grant_t;
   grant_t     exp_q[$];
   logic [7:0] rd_q[$];

   uio_bus_arbiter_if #(.NREQ(NREQ)) bus ();

   uio_bus_arbiter #(.NREQ(NREQ), .TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req = '0; bus.dir = '0; bus.wdata = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req = '0; bus.dir = '0; bus.wdata = '0; bus.uio_in = '0;
      step(); step();
      n_chk++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
      n_chk++; if (bus.uio_oe !== 8'h00) begin n_fail++; $display("FAIL reset_oe: got %h want 00", bus.uio_oe); end
      n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", bus.uio_out); end
      n_chk++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
      n_chk++; if (bus.owner_id !== 3'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", bus.owner_id); end
      rst = 1'b0;
      repeat (3) step();
      n_chk++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL idle_gnt: got %b want 0", bus.gnt); end
      n_chk++; if (bus.uio_oe !== 8'h00) begin n_fail++; $display("FAIL idle_oe: got %h want 00", bus.uio_oe); end
      n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL idle_out: got %h want 00", bus.uio_out); end
   endtask

   task automatic test_single();
      grant_t e;
      bus.req = 4'b0100; bus.dir = 4'b0100; bus.wdata[23:16] = 8'hA5;
      exp_q.push_back('{gnt: 4'b0100, id: 3'd2});
      step();
      e = exp_q.pop_front();
      n_chk++; if (bus.gnt !== e.gnt) begin n_fail++; $display("FAIL single_gnt: got %b want %b", bus.gnt, e.gnt); end
      n_chk++; if (bus.owner_id !== e.id) begin n_fail++; $display("FAIL single_id: got %0d want %0d", bus.owner_id, e.id); end
      n_chk++; if (bus.uio_oe !== 8'h00) begin n_fail++; $display("FAIL single_oe_early: got %h want 00", bus.uio_oe); end
      step();
      n_chk++; if (bus.uio_oe !== 8'hFF) begin n_fail++; $display("FAIL single_oe: got %h want ff", bus.uio_oe); end
      n_chk++; if (bus.uio_out !== 8'hA5) begin n_fail++; $display("FAIL single_out: got %h want a5", bus.uio_out); end
      bus.wdata[23:16] = 8'h3C;
      step();
      n_chk++; if (bus.uio_out !== 8'h3C) begin n_fail++; $display("FAIL single_live_wdata: got %h want 3c", bus.uio_out); end
      bus.req = '0;
      step();
      n_chk++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL single_release_gnt: got %b want 0", bus.gnt); end
      n_chk++; if (bus.uio_oe !== 8'hFF) begin n_fail++; $display("FAIL single_release_oe: got %h want ff", bus.uio_oe); end
      step();
      n_chk++; if (bus.uio_oe !== 8'h00) begin n_fail++; $display("FAIL single_turn_oe: got %h want 00", bus.uio_oe); end
      n_chk++; if (bus.uio_out !== 8'h3C) begin n_fail++; $display("FAIL single_out_hold: got %h want 3c", bus.uio_out); end
      repeat (4) step();
   endtask

   task automatic test_round_robin();
      grant_t          e;
      logic [NREQ-1:0] prev;
      int held, gap, cyc;
      bit first;
      do_reset();
      for (int k = 0; k < 5; k++)
         exp_q.push_back('{gnt: NREQ'(1) << (k % NREQ), id: 3'(k % NREQ)});
      bus.req = '1; bus.dir = '0;
      prev = '0; held = 0; gap = 0; cyc = 0; first = 1'b1;
      while (exp_q.size() != 0 && cyc < 200) begin
         step(); cyc++;
         if (bus.gnt != '0) begin
            if (prev == '0) begin
               e = exp_q.pop_front();
               n_chk++; if (bus.gnt !== e.gnt) begin n_fail++; $display("FAIL rr_gnt: got %b want %b", bus.gnt, e.gnt); end
               n_chk++; if (bus.owner_id !== e.id) begin n_fail++; $display("FAIL rr_id: got %0d want %0d", bus.owner_id, e.id); end
               if (!first) begin
                  n_chk++; if (gap != TC + 1) begin n_fail++; $display("FAIL rr_gap: got %0d want %0d", gap, TC + 1); end
               end
               first = 1'b0; held = 0; gap = 0;
            end
            held++;
            if (held == 3) bus.req = bus.req & ~bus.gnt;
         end else begin
            if (prev != '0) begin
               n_chk++; if (held != 3) begin n_fail++; $display("FAIL rr_hold: got %0d want 3", held); end
            end
            gap++;
            bus.req = '1;
         end
         prev = bus.gnt;
      end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_timeout: got %0d pending want 0", exp_q.size()); end
      exp_q.delete();
      bus.req = '0;
      repeat (6) step();
   endtask

   task automatic test_turnaround();
      grant_t e;
      int zero_oe, cyc;
      do_reset();
      bus.req = 4'b0010; bus.dir = 4'b0010;
      bus.wdata[15:8] = 8'h5A; bus.wdata[31:24] = 8'h77;
      exp_q.push_back('{gnt: 4'b0010, id: 3'd1});
      exp_q.push_back('{gnt: 4'b1000, id: 3'd3});
      step();
      e = exp_q.pop_front();
      n_chk++; if (bus.gnt !== e.gnt) begin n_fail++; $display("FAIL ta_gnt1: got %b want %b", bus.gnt, e.gnt); end
      bus.req[3] = 1'b1;
      step();
      n_chk++; if (bus.uio_oe !== 8'hFF || bus.uio_out !== 8'h5A) begin n_fail++; $display("FAIL ta_drive: got oe %h out %h want ff 5a", bus.uio_oe, bus.uio_out); end
      step();
      n_chk++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL ta_no_steal: got %b want 0010", bus.gnt); end
      bus.req[1] = 1'b0;
      zero_oe = 0; cyc = 0;
      step();
      while (bus.gnt == '0 && cyc < 20) begin
         if (bus.uio_oe == 8'h00) zero_oe++;
         step(); cyc++;
      end
      n_chk++; if (zero_oe < TC) begin n_fail++; $display("FAIL ta_oe_gap: got %0d want >= %0d", zero_oe, TC); end
      e = exp_q.pop_front();
      n_chk++; if (bus.gnt !== e.gnt) begin n_fail++; $display("FAIL ta_gnt2: got %b want %b", bus.gnt, e.gnt); end
      n_chk++; if (bus.owner_id !== e.id) begin n_fail++; $display("FAIL ta_id2: got %0d want %0d", bus.owner_id, e.id); end
      n_chk++; if (bus.uio_oe !== 8'h00) begin n_fail++; $display("FAIL ta_oe_at_gnt: got %h want 00", bus.uio_oe); end
      step();
      n_chk++; if (bus.uio_oe !== 8'h00 || bus.uio_out !== 8'h77) begin n_fail++; $display("FAIL ta_read_owner: got oe %h out %h want 00 77", bus.uio_oe, bus.uio_out); end
      bus.req = '0;
      repeat (6) step();
   endtask

   task automatic test_timeout();
      grant_t e;
      int held, gap, cyc;
      do_reset();
      bus.req = 4'b0001; bus.dir = 4'b0001;
      exp_q.push_back('{gnt: 4'b0001, id: 3'd0});
      step();
      e = exp_q.pop_front();
      n_chk++; if (bus.gnt !== e.gnt) begin n_fail++; $display("FAIL to_gnt0: got %b want %b", bus.gnt, e.gnt); end
      bus.req[1] = 1'b1;
      held = 1; gap = 0; cyc = 0;
`ifdef UIO_ARB_TIMEOUT_EN
      exp_q.push_back('{gnt: 4'b0010, id: 3'd1});
      while (bus.gnt[0] && cyc < 50) begin
         step(); cyc++;
         if (bus.gnt[0]) held++;
      end
      n_chk++; if (held != MH) begin n_fail++; $display("FAIL to_hold: got %0d want %0d", held, MH); end
      while (bus.gnt == '0 && cyc < 50) begin gap++; step(); cyc++; end
      n_chk++; if (gap != TC + 1) begin n_fail++; $display("FAIL to_gap: got %0d want %0d", gap, TC + 1); end
      e = exp_q.pop_front();
      n_chk++; if (bus.gnt !== e.gnt) begin n_fail++; $display("FAIL to_gnt1: got %b want %b", bus.gnt, e.gnt); end
`else
      repeat (30) begin
         step(); cyc++;
         if (bus.gnt == 4'b0001) held++;
      end
      n_chk++; if (held != cyc + 1) begin n_fail++; $display("FAIL to_persist: got %0d want %0d", held, cyc + 1); end
`endif
      bus.req = '0;
      repeat (6) step();
   endtask

   task automatic test_readback();
      logic [7:0] v, x;
      do_reset();
      bus.req = 4'b0100; bus.dir = 4'b0100;
      for (int c = 0; c < 12; c++) begin
         v = (c == 0) ? 8'h3C : 8'($urandom);
         bus.uio_in = v;
         rd_q.push_back(v);
         if (c == 4) bus.req = '0;
         step();
         x = rd_q.pop_front();
         n_chk++; if (bus.rdata !== x) begin n_fail++; $display("FAIL rb_rdata[%0d]: got %h want %h", c, bus.rdata, x); end
      end
      #2 rst = 1'b1;
      #1;
      n_chk++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL rb_reset: got %h want 00", bus.rdata); end
      bus.uio_in = 8'h3C;
      step();
      #2 rst = 1'b0;
      step();
      n_chk++; if (bus.rdata !== 8'h3C) begin n_fail++; $display("FAIL rb_release: got %h want 3c", bus.rdata); end
      repeat (2) step();
   endtask

   task automatic test_reset_async();
      do_reset();
      bus.req = 4'b0100; bus.dir = 4'b0100; bus.wdata[23:16] = 8'hC3; bus.uio_in = 8'h81;
      repeat (3) step();
      #3 rst = 1'b1;
      #1;
      n_chk++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL async_gnt: got %b want 0", bus.gnt); end
      n_chk++; if (bus.uio_oe !== 8'h00) begin n_fail++; $display("FAIL async_oe: got %h want 00", bus.uio_oe); end
      n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL async_out: got %h want 00", bus.uio_out); end
      n_chk++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL async_rdata: got %h want 00", bus.rdata); end
      n_chk++; if (bus.owner_id !== 3'd0) begin n_fail++; $display("FAIL async_owner: got %0d want 0", bus.owner_id); end
      bus.req = 4'b0101;
      step();
      n_chk++; if (bus.gnt !== '0) begin n_fail++; $display("FAIL async_held: got %b want 0", bus.gnt); end
      #2 rst = 1'b0;
      exp_q.push_back('{gnt: 4'b0001, id: 3'd0});
      step();
      begin
         grant_t e;
         e = exp_q.pop_front();
         n_chk++; if (bus.gnt !== e.gnt) begin n_fail++; $display("FAIL async_first_gnt: got %b want %b", bus.gnt, e.gnt); end
      end
      bus.req = '0;
      repeat (6) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req = '0; bus.dir = '0; bus.wdata = '0; bus.uio_in = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_turnaround();
      test_timeout();
      test_readback();
      test_reset_async();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
